seq_match_logger: RTL
=====================

Name: seq_match_logger

Overview:
- Downstream consumer of the Moore "101" sequence detector.
- Samples the detector's one-cycle match pulse and keeps a saturating match count.
- Captures a free-running cycle timestamp for each match into a small FIFO.
- Software or a monitor drains the FIFO over a valid/ready interface. Overflow is counted, never silent.

Parameters:
TS_W, 16, timestamp counter width (wraps modulo 2^TS_W)
CNT_W, 16, match counter width (saturating)
DEPTH, 8, FIFO entries; power of two, >= 2
DROP_W, 8, dropped-event counter width (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  event capture enable
clr  input  1  synchronous clear of counters, FIFO, flags
y_in  input  1  detector match output, registered-state Moore output, stable for the whole cycle
ts_ready  input  1  consumer accepts head entry
ts_valid  output  1  FIFO non-empty
ts_data  output  TS_W  timestamp at FIFO head (show-ahead)
match_cnt  output  CNT_W  accepted-or-dropped match count, saturating
cnt_sat  output  1  match_cnt has reached all-ones
fifo_full  output  1  DEPTH entries held
drop_cnt  output  DROP_W  events lost to full FIFO, saturating
ovf  output  1  sticky: at least one event dropped since reset/clr

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous, active-low.
- Reset (rst=0, any time, including mid-operation):
  - ts counter = 0, match_cnt = 0, drop_cnt = 0.
  - FIFO emptied: pointers 0, ts_valid = 0, fifo_full = 0.
  - cnt_sat = 0, ovf = 0, ts_data = 0.
- Timestamp: ts increments by 1 every clock, independent of en, and wraps all-ones -> 0.
- Event definition:
  - event = y_in & en, sampled at the rising edge.
  - Every cycle with y_in=1 is one event; there is no edge detection. The 101 detector cannot assert y on two consecutive cycles, but back-to-back highs still count as two events.
- On an event at edge k:
  - The logged timestamp is the ts value present before edge k.
  - match_cnt increments unless saturated.
- Write side:
  - If the FIFO is not full, or a pop occurs at the same edge, the timestamp is written.
  - Otherwise the event is dropped: drop_cnt increments (saturating) and ovf is set.
  - A dropped event still counts in match_cnt.
- Read side:
  - Pop at an edge when ts_valid & ts_ready.
  - ts_data always shows the head entry; it holds its value while ts_valid=1 & ts_ready=0.
  - ts_ready while empty has no effect.
- Simultaneous push and pop:
  - When full: both occur and the occupancy stays DEPTH.
  - When empty: the pop does not happen (ts_valid=0); the push occurs.
- Latency: event at edge k on an empty FIFO -> ts_valid=1 and ts_data valid in the cycle after edge k.
- Pointers: log2(DEPTH)+1 bits; full and empty are derived from the MSB compare. Wrap-around is exercised by DEPTH+1 writes.
- clr=1 at an edge:
  - Same effect as reset, except ts restarts at 0 on the next edge.
  - clr has priority: an event or pop in the same cycle is discarded and not counted.
- Control FSM, states IDLE, RUN, FULL:
  - IDLE: FIFO empty.
  - RUN: 0 < occupancy < DEPTH.
  - FULL: occupancy = DEPTH.
  - Transitions follow push/pop per the rules above. clr/rst -> IDLE.
  - fifo_full = (state==FULL); ts_valid = (state!=IDLE).
- All outputs are registered or decoded directly from state/pointers. There is no combinational path from y_in to any output.

Decomposition:
- Shared package seq_det_pkg holds:
  - FSM state encoding for IDLE/RUN/FULL (2-bit).
  - Default widths TS_W/CNT_W/DROP_W/DEPTH.
  - Saturating-increment function.
- One natural sub-module: ts_fifo, a synchronous show-ahead FIFO parameterized by width and depth, with push/pop/full/empty and same-edge push-when-full-with-pop support.
- The top level holds the timestamp counter, event qualification, counters and the FSM.

Test Plan:
- Reset mid-stream: fill 3 entries, pull rst low asynchronously between edges -> all outputs 0 immediately, ts restarts at 0 after release.
- Detector stream x=1,0,1,0,1 with detector y high at ts=3 and ts=5, ts_ready=1 -> ts_data 3 then 5, match_cnt=2, ts_valid pulses one cycle after each event.
- ts_ready=0, 10 events with DEPTH=8 -> fifo_full=1 after 8, drop_cnt=2, ovf=1, match_cnt=10; draining then returns the first 8 timestamps in order.
- FIFO full, event and ts_ready=1 on the same edge -> pop and push both occur, occupancy stays 8, drop_cnt unchanged.
- clr asserted in the same cycle as y_in=1 -> event not counted, FIFO empty, match_cnt=0, ovf cleared. en=0 with y_in=1 -> no change.
- Wrap and saturation, using TS_W=4 and CNT_W=4:
  - Event at ts=15, then ts=0 -> logged 15, 0.
  - 17 events -> match_cnt=15, cnt_sat=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM encoding, default widths and saturating increment for the match logger.
package seq_det_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FULL = 2'd2} state_e;

    localparam int TS_W_DEF   = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int DROP_W_DEF = 8;

    // Increment v, holding at the all-ones value of a w-bit counter (w < 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return (v >= m) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: show-ahead synchronous FIFO; a push while full is accepted when a pop happens on the same edge.
module ts_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_pop, do_push;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is forced to zero when empty so reset/clear present a clean output.
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/seq_match_logger.sv
// seq_match_logger: counts detector match pulses and logs their cycle timestamps into a drainable FIFO.
module seq_match_logger
    import seq_det_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              y_in,
    input  logic              ts_ready,
    output logic              ts_valid,
    output logic [TS_W-1:0]   ts_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat,
    output logic              fifo_full,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [TS_W-1:0]   ts_q;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              ovf_q, ovf_d;
    logic              evt, pop, push, full_w, empty_w;
    logic [AW:0]       count, occ_d;

    // clr wins over any event or pop in the same cycle.
    assign evt   = y_in & en & ~clr;
    assign pop   = ts_ready & ~empty_w & ~clr;
    assign push  = evt & (~full_w | pop);
    assign occ_d = count + (AW+1)'(push) - (AW+1)'(pop);

    ts_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (ts_q),
        .dout  (ts_data),
        .full  (full_w),
        .empty (empty_w),
        .count (count)
    );

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q;
        if (clr) begin
            state_d     = IDLE;
            match_cnt_d = '0;
            drop_cnt_d  = '0;
            ovf_d       = 1'b0;
        end else begin
            if (evt) match_cnt_d = CNT_W'(sat_inc(32'(match_cnt_q), CNT_W));
            if (evt && !push) begin
                drop_cnt_d = DROP_W'(sat_inc(32'(drop_cnt_q), DROP_W));
                ovf_d      = 1'b1;
            end
            state_d = (occ_d == '0) ? IDLE : (occ_d == (AW+1)'(DEPTH)) ? FULL : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= clr ? '0 : ts_q + TS_W'(1);
            match_cnt_q <= match_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ts_valid  = state_q != IDLE;
    assign fifo_full = state_q == FULL;
    assign cnt_sat   = &match_cnt_q;
    assign match_cnt = match_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign ovf       = ovf_q;

endmodule
